// File: rtl/wb_interconnect.sv
// wb_interconnect: single-master, multi-slave Wishbone-style fabric.
// The master's chipselect picks one slave channel. The fabric strobes that
// slave and waits for its ack, or generates the ack itself for slaves flagged
// in FIXED_MASK. It reports a bus error on an unmapped chipselect or on a
// timeout, and records the faulting address and a saturating fault count.
// CSW must be wide enough that 2**CSW > NSLAVE.
module wb_interconnect #(
  parameter int                NSLAVE     = 8,
  parameter int                DW         = 32,
  parameter int                AW         = 32,
  parameter int                CSW        = 4,
  parameter int                TIMEOUT    = 255,
  parameter logic [NSLAVE-1:0] FIXED_MASK = '0,
  parameter int                FIXED_LAT  = 2
) (
  input  logic                 sysclock,
  input  logic                 rst_n,
  input  logic                 m_cyc_i,
  input  logic                 m_we_i,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [CSW-1:0]       cs_i,
  output logic [DW-1:0]        m_dat_o,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [NSLAVE-1:0]    s_stb_o,
  input  logic [NSLAVE*DW-1:0] s_dat_i,
  input  logic [NSLAVE-1:0]    s_ack_i,
  output logic [AW-1:0]        fault_adr_o,
  output logic [15:0]          fault_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CSW-1:0] cur;
  logic [15:0]    wait_cnt;
  logic [7:0]     lat_sr;
  logic           cs_valid;
  logic           sel_ack;
  logic           sel_fixed;
  logic [DW-1:0]  sel_dat;
  logic           ack_src;
  logic           timeout_hit;
  logic           unused_we;

  // The write flag only travels alongside the cycle; the fabric never looks at it.
  assign unused_we = m_we_i;

  assign cs_valid    = (cs_i != '0) && (32'(cs_i) <= 32'(NSLAVE));
  assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));
  assign ack_src     = sel_fixed ? lat_sr[FIXED_LAT-1] : sel_ack;

  // Pick the ack, read data and fixed-latency flag of the latched slave.
  always_comb begin
    sel_ack   = 1'b0;
    sel_fixed = 1'b0;
    sel_dat   = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (cur == CSW'(i + 1)) begin
        sel_ack   = s_ack_i[i];
        sel_fixed = FIXED_MASK[i];
        sel_dat   = s_dat_i[i*DW +: DW];
      end
    end
  end

  // State register; reset drops any transfer in flight.
  always_ff @(posedge sysclock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a master abort beats an ack, and an ack beats a timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m_cyc_i) begin
          state_next = cs_valid ? ACTIVE : ERROR;
        end
      end
      ACTIVE: begin
        if (!m_cyc_i) begin
          state_next = IDLE;
        end else if (ack_src) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = ERROR;
        end
      end
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs that follow directly from the state and the latched slave.
  always_comb begin
    s_stb_o = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (state == ACTIVE && cur == CSW'(i + 1)) begin
        s_stb_o[i] = 1'b1;
      end
    end
    m_ack_o = (state == DONE);
    m_err_o = (state == ERROR);
    busy_o  = (state != IDLE);
  end

  // Datapath: slave latch, wait counter, fixed-ack shifter, read data and fault log.
  always_ff @(posedge sysclock or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= '0;
      wait_cnt    <= '0;
      lat_sr      <= '0;
      m_dat_o     <= '0;
      fault_adr_o <= '0;
      fault_cnt_o <= '0;
    end else begin
      if (state == IDLE && m_cyc_i && cs_valid) begin
        cur      <= cs_i;
        wait_cnt <= '0;
        lat_sr   <= 8'd1;
      end else if (state == ACTIVE) begin
        wait_cnt <= wait_cnt + 16'd1;
        lat_sr   <= lat_sr << 1;
      end
      if (state == ACTIVE && state_next == DONE) begin
        m_dat_o <= sel_dat;
      end
      if (state_next == ERROR) begin
        fault_adr_o <= m_adr_i;
        if (fault_cnt_o != 16'hFFFF) begin
          fault_cnt_o <= fault_cnt_o + 16'd1;
        end
      end
    end
  end

endmodule
